// File: rtl/port_soft_reset_sequencer_if.sv
// rtl/port_soft_reset_sequencer_if.sv - port control, TX A monitor and port reset signals of one soft-reset sequencer
interface port_soft_reset_sequencer_if #(
  parameter int OUTST_W = 10
);
  logic               soft_rst_req;
  logic               soft_rst_ack;
  logic               tx_tvalid;
  logic               tx_tready;
  logic               tx_tlast;
  logic               tx_block;
  logic               rd_issue;
  logic               cpl_done;
  logic               port_rst_n;
  logic               timeout_err;
  logic [OUTST_W-1:0] outstanding;

  // Sequencer side
  modport slave (
    input  soft_rst_req, tx_tvalid, tx_tready, tx_tlast, rd_issue, cpl_done,
    output soft_rst_ack, tx_block, port_rst_n, timeout_err, outstanding
  );

  // Port control / AFU side
  modport master (
    output soft_rst_req, tx_tvalid, tx_tready, tx_tlast, rd_issue, cpl_done,
    input  soft_rst_ack, tx_block, port_rst_n, timeout_err, outstanding
  );
endinterface

// File: rtl/port_soft_reset_sequencer.sv
// rtl/port_soft_reset_sequencer.sv - per-port soft-reset sequencer that quiesces TX A and host reads before holding port reset
module port_soft_reset_sequencer #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int OUTST_W         = 10,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  port_soft_reset_sequencer_if.slave    bus
);

  localparam int                 TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]        HOLD_INIT = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [OUTST_W-1:0] OUT_MAX   = {OUTST_W{1'b1}};

  typedef enum logic [2:0] {
    S_HOLD,
    S_ACK,
    S_RUN,
    S_DRAIN,
    S_WAIT_CPL
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_hold_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [OUTST_W-1:0] r_outstanding;
  logic               r_in_pkt;
  logic               r_port_rst_n;
  logic               r_ack;
  logic               r_timeout_err;
  logic               w_tmo_last;
  logic               w_tmo_hit;
  logic               w_beat;

  assign w_beat     = bus.tx_tvalid && bus.tx_tready;
  assign w_tmo_last = (r_tmo_cnt == TMO_LAST);

  // Next state; a normal quiesce exit always wins over the timeout in the same cycle
  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.soft_rst_req) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_in_pkt) begin
          w_next = S_WAIT_CPL;
        end else if (w_tmo_last) begin
          w_next    = S_HOLD;
          w_tmo_hit = 1'b1;
        end
      end
      S_WAIT_CPL: begin
        if (r_outstanding == '0) begin
          w_next = S_HOLD;
        end else if (w_tmo_last) begin
          w_next    = S_HOLD;
          w_tmo_hit = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == 16'd0) w_next = S_ACK;
      end
      S_ACK: begin
        if (!bus.soft_rst_req) w_next = S_RUN;
      end
      default: w_next = S_HOLD;
    endcase
  end

  // State register and registered port reset / ack / sticky error, all derived from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_HOLD;
      r_port_rst_n  <= 1'b0;
      r_ack         <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_port_rst_n  <= (w_next == S_RUN) || (w_next == S_DRAIN) || (w_next == S_WAIT_CPL);
      r_ack         <= (w_next == S_ACK);
      r_timeout_err <= r_timeout_err || w_tmo_hit;
    end
  end

  // Reset hold counter: loaded on entry to HOLD, counts down to zero while in HOLD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= HOLD_INIT;
    end else if ((w_next == S_HOLD) && (r_state != S_HOLD)) begin
      r_hold_cnt <= HOLD_INIT;
    end else if ((r_state == S_HOLD) && (r_hold_cnt != 16'd0)) begin
      r_hold_cnt <= r_hold_cnt - 16'd1;
    end
  end

  // Quiesce timeout counter: cleared while running, advances through DRAIN and WAIT_CPL
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_tmo_cnt <= '0;
    end else if (((r_state == S_DRAIN) || (r_state == S_WAIT_CPL)) && !w_tmo_last) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Outstanding host reads: saturating up/down count, flushed while the port is in reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outstanding <= '0;
    end else if (r_state == S_HOLD) begin
      r_outstanding <= '0;
    end else if (bus.rd_issue && !bus.cpl_done) begin
      if (r_outstanding != OUT_MAX) r_outstanding <= r_outstanding + 1'b1;
    end else if (!bus.rd_issue && bus.cpl_done) begin
      if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
    end
  end

  // TX A packet tracker: high between the first accepted beat and the tlast beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_pkt <= 1'b0;
    end else if (w_beat) begin
      r_in_pkt <= !bus.tx_tlast;
    end
  end

  assign bus.tx_block     = (r_state != S_RUN) && !r_in_pkt;
  assign bus.port_rst_n   = r_port_rst_n;
  assign bus.soft_rst_ack = r_ack;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.outstanding  = r_outstanding;

endmodule

// File: tb/tb_port_soft_reset_sequencer.sv
// tb/tb_port_soft_reset_sequencer.sv - scoreboard bench for port_soft_reset_sequencer
module tb_port_soft_reset_sequencer;

  localparam int N    = 16;
  localparam int OW   = 10;
  localparam int T    = 64;
  localparam int MAXO = (1 << OW) - 1;
  localparam int INF  = 1000000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_soft_reset_sequencer_if #(.OUTST_W(OW)) bus ();

  port_soft_reset_sequencer #(
    .RST_HOLD_CYCLES(N),
    .OUTST_W        (OW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;     // 0: power-on release, 1: soft reset
    int e0;       // release edge (kind 0) or edge the request is taken in RUN (kind 1)
    int quiesce;  // edges from request to port_rst_n falling
    bit tmo;      // expected timeout_err at acknowledge
  } exp_t;

  exp_t exp_q[$];
  int   cpl_offs[$];
  int   m_outst = 0;
  bit   m_tmo   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!(bus.port_rst_n === 1'b1 && bus.soft_rst_ack === 1'b0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_run_bound", 1, 0);
  endtask

  // Monitor: compares each acknowledge / reset release against the queued expectation
  initial begin
    exp_t cur;
    bit   have   = 1'b0;
    bit   p_ack  = 1'b0;
    bit   p_prn  = 1'b0;
    int   fall_e = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ack = 1'b0;
        p_prn = 1'b0;
      end else begin
        if (!bus.port_rst_n && p_prn) fall_e = cyc;
        if (bus.soft_rst_ack && !p_ack) begin
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", 1, 0);
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            if (cur.kind == 0) begin
              chk("por_ack_edge", cyc, cur.e0 + N);
              chk("por_prn_low_at_ack", bus.port_rst_n, 0);
              chk("por_tmo_err", bus.timeout_err, 0);
            end else begin
              chk("quiesce_len", fall_e - cur.e0, cur.quiesce);
              chk("hold_len", cyc - fall_e, N);
              chk("tmo_err_at_ack", bus.timeout_err, cur.tmo);
              chk("txblock_at_ack", bus.tx_block, 1);
            end
            chk("outst_at_ack", bus.outstanding, 0);
          end
        end
        if (bus.port_rst_n && !p_prn && have) begin
          chk("ack_low_at_release", bus.soft_rst_ack, 0);
          chk("txblock_run", bus.tx_block, 0);
          if (cur.kind == 0) chk("por_release_edge", cyc, cur.e0 + N + 1);
        end
        p_ack = bus.soft_rst_ack;
        p_prn = bus.port_rst_n;
      end
    end
  end

  // One soft-reset sequence; the expected quiesce length follows from when the
  // in-flight packet ends, when the last outstanding read completes, and the timeout.
  task automatic run_seq(input int k, input bit has_pkt, input int len, input int r,
                         input bit early, input int drop_off);
    int  rstart, base, e0, p, d, c, h, e, cur_o, hold_left, u;
    bit  tmo, seen_ack, done, hit;
    wait_run();
    for (int j = 0; j < k; j++) begin
      bus.rd_issue = 1'b1;
      tick();
      if (m_outst < MAXO) m_outst++;
    end
    bus.rd_issue = 1'b0;
    chk("outst_issued", bus.outstanding, m_outst);

    rstart = has_pkt ? r : 0;
    base   = cyc;
    e0     = base + rstart + 1;
    p      = has_pkt ? base + len : -1000;
    d      = imax(p, e0) + 1;
    cpl_offs.sort();
    if (m_outst == 0)                    c = -1000;
    else if (cpl_offs.size() < m_outst)  c = INF;
    else                                 c = e0 + cpl_offs[m_outst - 1];
    h   = imax(d, c) + 1;
    tmo = (h - e0) > T;
    if (tmo) h = e0 + T;
    m_tmo = m_tmo | tmo;
    exp_q.push_back('{kind: 1, e0: e0, quiesce: h - e0, tmo: m_tmo});

    cur_o     = m_outst;
    seen_ack  = 1'b0;
    done      = 1'b0;
    hold_left = $urandom_range(0, 3);
    for (int t = 0; t < 400 && !done; t++) begin
      bus.tx_tvalid = has_pkt && (t < len);
      bus.tx_tready = has_pkt && (t < len);
      bus.tx_tlast  = has_pkt && (t == len - 1);
      if (t == rstart) bus.soft_rst_req = 1'b1;
      if (early && t == rstart + drop_off) bus.soft_rst_req = 1'b0;
      hit = 1'b0;
      foreach (cpl_offs[i]) if (cpl_offs[i] == t - rstart) hit = 1'b1;
      bus.cpl_done = hit;
      tick();
      e = cyc;
      u = t + 1;
      if (hit && cur_o > 0) cur_o--;
      if (e < h) chk("outst_track", bus.outstanding, cur_o);
      if (has_pkt && u >= rstart + 1 && u <= len - 1) chk("txblock_inflight", bus.tx_block, 0);
      if (has_pkt && u == len) chk("txblock_after_tlast", bus.tx_block, 1);
      if (bus.soft_rst_ack) seen_ack = 1'b1;
      if (!early && seen_ack && bus.soft_rst_req) begin
        if (hold_left == 0) bus.soft_rst_req = 1'b0;
        else hold_left--;
      end
      if (seen_ack && bus.port_rst_n && !bus.soft_rst_ack) done = 1'b1;
    end
    bus.tx_tvalid    = 1'b0;
    bus.tx_tready    = 1'b0;
    bus.tx_tlast     = 1'b0;
    bus.cpl_done     = 1'b0;
    bus.soft_rst_req = 1'b0;
    if (!done) chk("seq_bound", 1, 0);
    m_outst = 0;
    cpl_offs.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, len, r, dof;
    bit hp, early;
    bus.soft_rst_req = 1'b0;
    bus.tx_tvalid    = 1'b0;
    bus.tx_tready    = 1'b0;
    bus.tx_tlast     = 1'b0;
    bus.rd_issue     = 1'b0;
    bus.cpl_done     = 1'b0;
    repeat (3) tick();
    chk("rst_port_rst_n", bus.port_rst_n, 0);
    chk("rst_ack", bus.soft_rst_ack, 0);
    chk("rst_tmo_err", bus.timeout_err, 0);
    chk("rst_outst", bus.outstanding, 0);
    chk("rst_tx_block", bus.tx_block, 1);

    // Power-on release
    exp_q.push_back('{kind: 0, e0: cyc, quiesce: 0, tmo: 1'b0});
    rst_n = 1'b1;
    wait_run();

    // Mid-packet request: 4-beat packet, request with beat 2
    run_seq(0, 1'b1, 4, 1, 1'b0, 0);

    // Three outstanding reads completing at +10/+20/+30
    cpl_offs = '{10, 20, 30};
    run_seq(3, 1'b0, 0, 0, 1'b0, 0);
    chk("tmo_err_after_cpl_seq", bus.timeout_err, 0);

    // Counter arithmetic in RUN
    wait_run();
    bus.rd_issue = 1'b1;
    repeat (5) tick();
    bus.rd_issue = 1'b0;
    chk("outst_five", bus.outstanding, 5);
    bus.rd_issue = 1'b1;
    bus.cpl_done = 1'b1;
    tick();
    bus.rd_issue = 1'b0;
    chk("outst_simul", bus.outstanding, 5);
    repeat (5) tick();
    chk("outst_drained", bus.outstanding, 0);
    tick();
    bus.cpl_done = 1'b0;
    chk("outst_dec_at_zero", bus.outstanding, 0);

    // Completion lands exactly on the last timeout cycle: normal exit wins
    cpl_offs = '{63};
    run_seq(1, 1'b0, 0, 0, 1'b0, 0);
    chk("tmo_err_boundary", bus.timeout_err, 0);

    // Saturation
    wait_run();
    bus.rd_issue = 1'b1;
    repeat (MAXO) tick();
    chk("outst_at_max", bus.outstanding, MAXO);
    tick();
    bus.rd_issue = 1'b0;
    chk("outst_saturated", bus.outstanding, MAXO);
    m_outst = MAXO;
    run_seq(0, 1'b0, 0, 0, 1'b0, 0);

    // One read never completes, then completion one cycle too late
    run_seq(1, 1'b0, 0, 0, 1'b0, 0);
    cpl_offs = '{64};
    run_seq(1, 1'b0, 0, 0, 1'b0, 0);

    // Randomized sequences
    for (int n = 0; n < 20; n++) begin
      k     = $urandom_range(0, 3);
      hp    = 1'($urandom_range(0, 1));
      len   = $urandom_range(2, 6);
      r     = $urandom_range(0, len - 1);
      early = 1'($urandom_range(0, 1));
      dof   = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) cpl_offs.push_back($urandom_range(j * 12 + 1, j * 12 + 11));
      if (k > 0 && $urandom_range(0, 4) == 0) void'(cpl_offs.pop_back());
      run_seq(k, hp, len, r, early, dof);
    end
    wait_run();
    chk("tmo_err_sticky_run", bus.timeout_err, 1);

    // rst_n asserted during WAIT_CPL
    bus.rd_issue = 1'b1;
    tick();
    bus.rd_issue = 1'b0;
    bus.soft_rst_req = 1'b1;
    repeat (10) tick();
    chk("pre_abort_prn_high", bus.port_rst_n, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_prn_async", bus.port_rst_n, 0);
    chk("abort_tmo_err", bus.timeout_err, 0);
    chk("abort_outst", bus.outstanding, 0);
    chk("abort_ack", bus.soft_rst_ack, 0);
    chk("abort_queue_empty", exp_q.size(), 0);
    bus.soft_rst_req = 1'b0;
    m_outst = 0;
    m_tmo   = 1'b0;
    tick();
    exp_q.push_back('{kind: 0, e0: cyc, quiesce: 0, tmo: 1'b0});
    rst_n = 1'b1;
    wait_run();

    for (int n = 0; n < 6; n++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) cpl_offs.push_back($urandom_range(j * 12 + 1, j * 12 + 11));
      len = $urandom_range(2, 6);
      run_seq(k, 1'($urandom_range(0, 1)), len, $urandom_range(0, len - 1),
              1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end
    wait_run();
    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_tmo_err", bus.timeout_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_soft_reset_sequencer.md
Name: port_soft_reset_sequencer

Overview:
- Per-port soft-reset sequencer feeding the port_rst_n input of afu_main.
- Takes a level soft-reset request from port control. Before asserting port reset it quiesces the AFU:
  - blocks new TX A packets at a packet boundary;
  - waits for outstanding host reads to complete, or for a timeout.
- Then holds port_rst_n low and acknowledges. Releases reset when the request drops.
- One instance per port.

Parameters:
RST_HOLD_CYCLES, 16, minimum cycles port_rst_n is held low per reset (1..2^16-1)
OUTST_W, 10, width of outstanding-read counter
TIMEOUT_CYCLES, 4096, drain/completion timeout in cycles (>=1)

Ports:
clk  in  1  port clock
rst_n  in  1  asynchronous active-low reset
soft_rst_req  in  1  level request for port soft reset
soft_rst_ack  out  1  high while port held in reset after quiesce
tx_tvalid  in  1  AFU TX A tvalid (monitor)
tx_tready  in  1  AFU TX A tready (monitor)
tx_tlast  in  1  AFU TX A tlast (monitor)
tx_block  out  1  gate: downstream must not start a new TX A packet while high
rd_issue  in  1  pulse: one read request accepted on TX A/B
cpl_done  in  1  pulse: final completion of one read received
port_rst_n  out  1  active-low port reset to afu_main
timeout_err  out  1  sticky: quiesce ended by timeout
outstanding  out  OUTST_W  current outstanding-read count (debug)

Behaviour:
- States: HOLD, ACK, RUN, DRAIN, WAIT_CPL.
- Async reset (rst_n=0) values:
  - state=HOLD, hold_cnt=RST_HOLD_CYCLES-1;
  - port_rst_n=0, soft_rst_ack=0, timeout_err=0, outstanding=0, in_pkt=0, timeout counter=0.
- Outputs: port_rst_n, soft_rst_ack and timeout_err are registered. tx_block is combinational from registers only: tx_block = (state!=RUN) && !in_pkt.
- in_pkt: set on a beat tvalid&tready&!tlast; cleared on a beat tvalid&tready&tlast. Updated in every state.
- outstanding:
  - +1 on rd_issue, -1 on cpl_done; both in the same cycle = no change.
  - Saturates at 2^OUTST_W-1. A decrement at 0 is ignored.
  - Forced to 0 in HOLD.
- RUN: port_rst_n=1, ack=0. soft_rst_req=1 -> DRAIN and clear timeout counter.
- DRAIN: in_pkt=0 -> WAIT_CPL. An in-flight packet completes unblocked. tx_block rises in the cycle after the tlast beat.
- WAIT_CPL: outstanding==0 -> HOLD, load hold_cnt=RST_HOLD_CYCLES-1.
- Timeout:
  - The counter increments each cycle in DRAIN and WAIT_CPL.
  - When it reaches TIMEOUT_CYCLES-1 and the normal exit condition is false, set timeout_err and go to HOLD.
  - A normal exit in the same cycle takes priority; no error is set.
- HOLD: port_rst_n=0. hold_cnt decrements each cycle; at 0 -> ACK.
- ACK: port_rst_n=0, soft_rst_ack=1. soft_rst_req=0 -> RUN; port_rst_n=1 and ack=0 appear on the next clock.
- Exit from power-on reset: HOLD -> ACK. If soft_rst_req=0, the block goes straight to RUN.
  - port_rst_n first rises RST_HOLD_CYCLES+1 cycles after rst_n deasserts.
- soft_rst_req deasserted during DRAIN/WAIT_CPL/HOLD: the sequence is committed and continues to ACK, then exits to RUN immediately.
- soft_rst_req reasserted in the same cycle RUN is entered: DRAIN on the following cycle.
- timeout_err clears only on rst_n.
- rst_n asserted mid-sequence: immediate return to reset values; port_rst_n goes low asynchronously.

Test Plan:
- Power-on: RST_HOLD_CYCLES=16, rst_n released, req=0 -> port_rst_n=0 for 17 cycles then 1; ack pulses 1 cycle; tx_block=0 in RUN.
- Mid-packet request: 4-beat packet, req at beat 2 -> beats 3-4 accepted, tx_block=1 the cycle after tlast; port_rst_n low 16 cycles after WAIT_CPL exit; ack=1 until req=0.
- Outstanding reads: 3 rd_issue, then req, cpl_done at +10/+20/+30 -> stays in WAIT_CPL until the 3rd cpl; outstanding reads 3,2,1,0; timeout_err=0.
- Simultaneous rd_issue and cpl_done with outstanding=5 -> stays 5; cpl_done at 0 -> stays 0; 1023 issues + 1 more -> saturates at 1023.
- Timeout: TIMEOUT_CYCLES=64, 1 read never completed -> HOLD entered 64 cycles after DRAIN entry; timeout_err=1 sticky through the next RUN; outstanding=0.
- rst_n asserted during WAIT_CPL -> port_rst_n=0 asynchronously; on release the power-on sequence repeats; timeout_err=0.
